// File: rtl/audio_frame_writer_pkg.sv
// audio_frame_writer_pkg: shared FSM encodings, sample width and RAM address-width helper
package audio_frame_writer_pkg;
    localparam int SAMPLE_W = 16;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;
    function automatic int addr_w(input int frame_w, input int chan_w);
        return frame_w + chan_w;
    endfunction
endpackage

// File: rtl/audio_frame_writer_if.sv
// audio_frame_writer_if: sample stream, audio RAM write port, sequencer run/done and status
// master = the frame writer; slave = deserialiser/RAM/sequencer/control side
interface audio_frame_writer_if
    import audio_frame_writer_pkg::*;
#(
    parameter int CHAN_W  = 4,
    parameter int FRAME_W = 4
);
    logic [SAMPLE_W-1:0]                   in_data;
    logic                                  in_valid;
    logic                                  in_sync;
    logic [addr_w(FRAME_W, CHAN_W)-1:0]    wr_addr;
    logic [SAMPLE_W-1:0]                   wr_data;
    logic                                  wr_we;
    logic                                  seq_run;
    logic [FRAME_W-1:0]                    seq_frame;
    logic                                  seq_done;
    logic                                  busy;
    logic                                  overrun;
    logic                                  sync_err;
    logic                                  clr_err;
    modport master (
        input  in_data, in_valid, in_sync, seq_done, clr_err,
        output wr_addr, wr_data, wr_we, seq_run, seq_frame, busy, overrun, sync_err
    );
    modport slave (
        output in_data, in_valid, in_sync, seq_done, clr_err,
        input  wr_addr, wr_data, wr_we, seq_run, seq_frame, busy, overrun, sync_err
    );
endinterface

// File: rtl/audio_frame_writer_sync2.sv
// audio_frame_writer_sync2: two-flop synchroniser with asynchronous active-low reset
// ports: ck clock, rst active-low async reset, d async input, q synchronised output
module audio_frame_writer_sync2 (
    input  logic ck,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1;
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/audio_frame_writer.sv
// audio_frame_writer: writes channel samples into the circular audio frame buffer and runs the sequencer per frame
// ports: ck clock, rst active-low async reset, bus (master) carries sample input, RAM write, sequencer run/done, status
module audio_frame_writer
    import audio_frame_writer_pkg::*;
#(
    parameter int CHAN_W  = 4,
    parameter int FRAME_W = 4,
    parameter int NCHAN   = 8
) (
    input  logic                  ck,
    input  logic                  rst,
    audio_frame_writer_if.master  bus
);
    localparam int AW = addr_w(FRAME_W, CHAN_W);
    state_t              state;
    logic [CHAN_W-1:0]   chan, eff_chan;
    logic [FRAME_W-1:0]  wframe, last_frame, seq_frame;
    logic [AW-1:0]       wr_addr;
    logic [SAMPLE_W-1:0] wr_data;
    logic                wr_we, seq_run, overrun, sync_err;
    logic                frame_done, pending, flush_min, done_s;
    logic                accept_last, serr_set, ovr_set;
    audio_frame_writer_sync2 u_sync (.ck(ck), .rst(rst), .d(bus.seq_done), .q(done_s));
    // a sync marker forces the sample onto channel 0, abandoning any partial frame
    always_comb begin
        eff_chan    = bus.in_sync ? '0 : chan;
        accept_last = bus.in_valid && eff_chan == CHAN_W'(NCHAN - 1);
        serr_set    = bus.in_valid && bus.in_sync && chan != '0;
        ovr_set     = frame_done && pending;
    end
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            chan       <= '0;
            wframe     <= '0;
            last_frame <= '0;
            seq_frame  <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_we      <= 1'b0;
            seq_run    <= 1'b0;
            overrun    <= 1'b0;
            sync_err   <= 1'b0;
            frame_done <= 1'b0;
            pending    <= 1'b0;
            flush_min  <= 1'b0;
        end else begin
            wr_we      <= bus.in_valid;
            frame_done <= accept_last;
            overrun    <= ovr_set | (overrun & ~bus.clr_err);
            sync_err   <= serr_set | (sync_err & ~bus.clr_err);
            if (bus.in_valid) begin
                wr_addr <= {wframe, eff_chan};
                wr_data <= bus.in_data;
                chan    <= accept_last ? '0 : eff_chan + 1'b1;
            end
            if (accept_last) begin
                wframe     <= wframe + 1'b1;
                last_frame <= wframe;
            end
            case (state)
                IDLE: if (frame_done || pending) begin
                    seq_frame <= last_frame;
                    seq_run   <= 1'b1;
                    pending   <= 1'b0;
                    state     <= RUN;
                end
                RUN: begin
                    if (frame_done) pending <= 1'b1;
                    if (done_s) begin
                        seq_run   <= 1'b0;
                        flush_min <= 1'b0;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    // hold the sequencer in reset at least two cycles so it sees a negedge with rst low
                    if (frame_done) pending <= 1'b1;
                    flush_min <= 1'b1;
                    if (flush_min && !done_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.wr_addr   = wr_addr;
    assign bus.wr_data   = wr_data;
    assign bus.wr_we     = wr_we;
    assign bus.seq_run   = seq_run;
    assign bus.seq_frame = seq_frame;
    assign bus.busy      = state != IDLE;
    assign bus.overrun   = overrun;
    assign bus.sync_err  = sync_err;
endmodule

// File: tb/tb_audio_frame_writer.sv
// tb_audio_frame_writer: directed scoreboard bench for audio_frame_writer
module tb_audio_frame_writer;
    localparam int CW = 4;
    localparam int FW = 4;
    localparam int NC = 8;
    logic ck = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [23:0] wq[$];
    logic [3:0]  fq[$];
    logic [23:0] we;
    logic [3:0]  fe;
    logic [3:0]  m_wframe = '0;
    logic [3:0]  m_chan = '0;
    logic        prev_run = 1'b0;
    audio_frame_writer_if #(.CHAN_W(CW), .FRAME_W(FW)) bus ();
    audio_frame_writer #(.CHAN_W(CW), .FRAME_W(FW), .NCHAN(NC)) dut (.ck(ck), .rst(rst), .bus(bus));
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge ck) begin
        #1;
        if (bus.wr_we === 1'b1) begin
            chk("wr_expected", {31'b0, wq.size() != 0}, 1);
            if (wq.size() != 0) begin
                we = wq.pop_front();
                chk("wr_addr", {24'b0, bus.wr_addr}, {24'b0, we[23:16]});
                chk("wr_data", {16'b0, bus.wr_data}, {16'b0, we[15:0]});
            end
        end
        if (bus.seq_run === 1'b1 && !prev_run) begin
            chk("run_expected", {31'b0, fq.size() != 0}, 1);
            if (fq.size() != 0) begin
                fe = fq.pop_front();
                chk("seq_frame", {28'b0, bus.seq_frame}, {28'b0, fe});
            end
        end
        prev_run = bus.seq_run === 1'b1;
    end

    task automatic send(input logic [15:0] d, input logic s);
        logic [3:0] e;
        @(negedge ck);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sync  = s;
        e = s ? 4'd0 : m_chan;
        wq.push_back({m_wframe, e, d});
        if (e == 4'(NC - 1)) begin
            m_chan   = '0;
            m_wframe = m_wframe + 1'b1;
        end else m_chan = e + 1'b1;
    endtask

    task automatic idle(input int n);
        @(negedge ck);
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        repeat (n - 1) @(negedge ck);
    endtask

    task automatic frame(input logic [15:0] base);
        for (int i = 0; i < NC; i++) send(base + 16'(i), i == 0);
        idle(1);
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (bus.seq_run !== 1'b1 && n < 50) begin
            @(posedge ck); #1; n++;
        end
        chk({tag, "_run"}, {31'b0, bus.seq_run}, 1);
        chk({tag, "_busy"}, {31'b0, bus.busy}, 1);
    endtask

    task automatic handshake(input string tag);
        int n;
        wait_run(tag);
        repeat (20) @(posedge ck);
        @(negedge ck);
        bus.seq_done = 1'b1;
        n = 0;
        while (bus.seq_run !== 1'b0 && n < 50) begin
            @(posedge ck); #1; n++;
        end
        chk({tag, "_stop"}, {31'b0, bus.seq_run}, 0);
        @(negedge ck);
        bus.seq_done = 1'b0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 50) begin
            @(posedge ck); #1; n++;
            if (bus.busy === 1'b1) chk({tag, "_flush_low"}, {31'b0, bus.seq_run}, 0);
        end
        chk({tag, "_idle"}, {31'b0, bus.busy}, 0);
        chk({tag, "_flush_min"}, {31'b0, n >= 2}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_data  = '0;
        bus.seq_done = 1'b0;
        bus.clr_err  = 1'b0;
        #1;
        chk("rst_wr_we", {31'b0, bus.wr_we}, 0);
        chk("rst_wr_addr", {24'b0, bus.wr_addr}, 0);
        chk("rst_seq_run", {31'b0, bus.seq_run}, 0);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_overrun", {31'b0, bus.overrun}, 0);
        chk("rst_sync_err", {31'b0, bus.sync_err}, 0);
        repeat (3) @(negedge ck);
        rst = 1'b1;
        idle(2);
        // first frame: addresses 0x00..0x07, run with frame 0
        fq.push_back(4'd0);
        frame(16'h0100);
        handshake("f0");
        // frames 1..15 then wrap to 0
        for (int f = 1; f <= 16; f++) begin
            fq.push_back(4'(f));
            frame(16'h1000 + 16'(f << 4));
            handshake("wrap");
        end
        chk("wrap_wframe", {28'b0, m_wframe}, 1);
        // three frames with seq_done held low: frame 2 dropped, frame 3 runs next
        fq.push_back(4'd1);
        fq.push_back(4'd3);
        frame(16'h2000);
        frame(16'h2100);
        idle(3);
        chk("ovr_after_b", {31'b0, bus.overrun}, 0);
        frame(16'h2200);
        idle(3);
        chk("ovr_after_c", {31'b0, bus.overrun}, 1);
        handshake("ovr1");
        handshake("ovr3");
        chk("ovr_sticky", {31'b0, bus.overrun}, 1);
        @(negedge ck); bus.clr_err = 1'b1;
        @(negedge ck); bus.clr_err = 1'b0;
        chk("ovr_clr", {31'b0, bus.overrun}, 0);
        // resync at chan 3 in frame 4
        send(16'h3000, 1'b1);
        send(16'h3001, 1'b0);
        send(16'h3002, 1'b0);
        send(16'h30AA, 1'b1);
        chk("sync_model_wframe", {28'b0, m_wframe}, 4);
        fq.push_back(4'd4);
        for (int i = 1; i < NC; i++) send(16'h3100 + 16'(i), 1'b0);
        idle(2);
        chk("sync_err_set", {31'b0, bus.sync_err}, 1);
        handshake("sync");
        @(negedge ck); bus.clr_err = 1'b1;
        @(negedge ck); bus.clr_err = 1'b0;
        chk("sync_err_clr", {31'b0, bus.sync_err}, 0);
        // reset while running
        fq.push_back(4'd5);
        frame(16'h5000);
        wait_run("mid");
        send(16'h5FFF, 1'b1);
        @(posedge ck); #2;
        chk("mid_wr_we_pre", {31'b0, bus.wr_we}, 1);
        rst = 1'b0;
        #1;
        chk("mid_seq_run", {31'b0, bus.seq_run}, 0);
        chk("mid_wr_we", {31'b0, bus.wr_we}, 0);
        chk("mid_busy", {31'b0, bus.busy}, 0);
        m_wframe = '0;
        m_chan   = '0;
        idle(2);
        rst = 1'b1;
        idle(2);
        fq.push_back(4'd0);
        frame(16'h6000);
        handshake("post");
        idle(3);
        chk("wq_empty", 32'(wq.size()), 0);
        chk("fq_empty", 32'(fq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/audio_frame_writer.md
Name: audio_frame_writer

Overview:
- Producer end of the audio RAM that the sequencer reads: takes a serial stream of 16-bit channel samples and writes them into the circular frame buffer at {frame, chan}.
- On each completed frame, hands that frame index to the sequencer and starts it (holds its run input high), then drops run on done.
- Sits between the audio input deserialiser and the sequencer's audio RAM write port and run/done interface.

Parameters:
- CHAN_W, 4, channel index width; RAM address low field.
- FRAME_W, 4, frame index width; RAM address high field; frames wrap mod 2^FRAME_W.
- NCHAN, 8, channels per frame, 1..2^CHAN_W.

Ports:
- ck  in  1  clock; all logic on posedge ck.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  16  sample, two's complement.
- in_valid  in  1  one-cycle strobe; in_data is valid this cycle.
- in_sync  in  1  qualified by in_valid; marks channel 0 of a frame.
- wr_addr  out  FRAME_W+CHAN_W  audio RAM write address {wframe, chan}.
- wr_data  out  16  audio RAM write data.
- wr_we  out  1  audio RAM write enable.
- seq_run  out  1  drives sequencer rst; high = run, low = hold in reset.
- seq_frame  out  FRAME_W  frame index presented to sequencer; stable while seq_run is high.
- seq_done  in  1  sequencer done; may be asynchronous to posedge, double-registered internally.
- busy  out  1  FSM not in IDLE.
- overrun  out  1  sticky: a frame was dropped.
- sync_err  out  1  sticky: in_sync seen with chan != 0.
- clr_err  in  1  clears overrun and sync_err.

Behaviour:
- Reset (rst=0, async): every output 0; wframe=0, chan=0, pending=0, FSM=IDLE.
- Write path, latency 1 cycle:
  - in_valid at cycle t -> wr_we=1 at t+1 with wr_addr={wframe,chan}, wr_data=in_data.
  - wr_we=0 when no in_valid.
  - chan increments per accepted sample.
- Frame complete: accepted sample with chan==NCHAN-1.
  - Next cycle: chan=0, wframe=wframe+1 (wraps 2^FRAME_W-1 -> 0).
  - last_frame <= old wframe; frame_done pulse internal.
- in_sync with chan!=0:
  - Set sync_err.
  - Sample written as chan 0; chan <= 1.
  - Partial frame abandoned; wframe not advanced.
- in_sync with chan==0: normal.
- FSM, states IDLE, RUN, FLUSH:
  - IDLE: on frame_done or pending -> seq_frame <= last_frame, seq_run <= 1, pending <= 0, go RUN.
  - RUN: seq_run=1; on synced seq_done==1 -> seq_run <= 0, go FLUSH.
  - FLUSH: seq_run=0 for a minimum of 2 cycles and until synced seq_done==0 -> IDLE.
  - The 2-cycle minimum guarantees the sequencer sees at least one negedge with rst low.
- frame_done while FSM != IDLE:
  - Set pending; last_frame updates to the newest frame.
  - If pending was already 1, set overrun (older frame dropped).
- frame_done in IDLE on the same cycle pending=1: start with newest last_frame, clear pending, set overrun.
- seq_frame changes only on IDLE->RUN.
- Writes continue during RUN. Sequencer reads frames at or behind seq_frame, so no hazard unless its offset reaches the frame being written (software rule).
- clr_err: clears both sticky flags next cycle. A set event in the same cycle wins over clr_err.
- Reset mid-RUN: seq_run drops asynchronously; all state cleared.
- busy = (FSM != IDLE).

Decomposition:
- Shared package: FSM state encodings (IDLE=0, RUN=1, FLUSH=2) and address-width helper FRAME_W+CHAN_W, shared with the sequencer's address generator.
- One sub-module: sync2, a 2-flop synchroniser for seq_done with async active-low reset. All other logic in this module.

Test Plan:
- NCHAN=8; feed 8 samples 0x0100..0x0107, in_sync on first -> 8 writes at addr 0x00..0x07 one cycle after each in_valid; seq_run rises with seq_frame=0; wframe=1.
- Assert seq_done 20 cycles after run -> seq_run low ≥2 cycles; seq_done low -> busy=0.
- 16 consecutive frames -> wr_addr high nibble wraps 0xF -> 0x0; seq_frame sequence 0..15,0.
- Hold seq_done low across 3 frame completions -> overrun=1 after the second pending frame; next run uses newest frame index; clr_err -> overrun=0.
- in_sync at chan=3 -> sync_err=1; that sample written at {wframe,0}; wframe unchanged.
- rst=0 during RUN -> seq_run, wr_we, busy 0 immediately; after release, the first frame writes at addr 0x00.
